// File: rtl/motor_relu_vec_serializer.sv
// -----------------------------------------------------------------------------
// motor_relu_vec_serializer
//
// Takes one packed vector of N_ELEM non-negative ReLU outputs (unsigned Q6.14)
// and replays it one element per beat as signed ap_fixed<21,7> words to the
// serial dense layer. Each element is zero-extended by one bit, so its value
// is unchanged. Both sides use valid/ready handshakes. A new vector can be
// accepted on the last beat of the current one, so back-to-back vectors
// stream with no idle cycle.
//
// Ports
//   ap_clk    in   clock; all state changes on the rising edge
//   ap_rst_n  in   asynchronous active-low reset
//   in_vec    in   packed vector; element i = in_vec[i*W_IN +: W_IN]
//   in_vld    in   in_vec is valid
//   in_rdy    out  vector can be loaded this cycle (combinational on out_rdy)
//   out_data  out  current element, {1'b0, elem}
//   out_vld   out  out_data is valid
//   out_rdy   in   downstream accepts out_data
//   out_idx   out  index of the current element
//   out_last  out  current element is the final one of the vector
//   nz_count  out  nonzero elements in the most recently loaded vector
//   busy      out  a vector is being replayed (same as out_vld)
// -----------------------------------------------------------------------------
module motor_relu_vec_serializer #(
  parameter  int N_ELEM = 8,
  parameter  int W_IN   = 20,
  parameter  int W_OUT  = 21,
  localparam int IDX_W  = $clog2(N_ELEM),
  localparam int NZ_W   = $clog2(N_ELEM + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [N_ELEM*W_IN-1:0] in_vec,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [W_OUT-1:0]       out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic [NZ_W-1:0]        nz_count,
  output logic                   busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [NZ_W-1:0]  NZ_ONE   = NZ_W'(1);

  // Number of elements in a packed vector that are not zero.
  function automatic logic [NZ_W-1:0] count_nonzero(
    input logic [N_ELEM*W_IN-1:0] vec
  );
    logic [NZ_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (vec[i*W_IN +: W_IN] != '0) begin
        cnt = cnt + NZ_ONE;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [N_ELEM-1:0][W_IN-1:0]   vec_q, vec_d;
  logic [NZ_W-1:0]               nz_q, nz_d;

  logic last_s;
  logic load_s;
  logic beat_s;

  // Handshake decode from registered state.
  always_comb begin
    last_s = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    // A vector may load from IDLE, or on the final beat of the current one.
    in_rdy = (state_q == ST_IDLE) || (last_s && out_rdy);
    load_s = in_vld && in_rdy;
    beat_s = (state_q == ST_SEND) && out_rdy;
  end

  // Next-state logic: load wins, otherwise advance on an accepted beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    nz_d    = nz_q;
    if (load_s) begin
      // On the last beat a load replaces the return to IDLE.
      state_d = ST_SEND;
      idx_d   = '0;
      vec_d   = in_vec;
      nz_d    = count_nonzero(in_vec);
    end else if (beat_s) begin
      if (last_s) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + IDX_ONE;
      end
    end else begin
      // Idle with no load, or stalled: everything holds.
      state_d = state_q;
      idx_d   = idx_q;
    end
  end

  // State registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      nz_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      nz_q    <= nz_d;
    end
  end

  // Outputs are direct functions of the registered state and index.
  always_comb begin
    out_vld  = (state_q == ST_SEND);
    busy     = (state_q == ST_SEND);
    out_idx  = idx_q;
    out_last = last_s;
    nz_count = nz_q;
    out_data = {1'b0, vec_q[idx_q]};
  end

endmodule

// File: doc/motor_relu_vec_serializer.md
# motor_relu_vec_serializer

Consumer-side companion to the motor network's ReLU stage. It accepts one packed vector of N_ELEM non-negative 20-bit ReLU outputs and replays them one element per beat as signed ap_fixed<21,7> words to the next serial dense layer. Elements are zero-extended, so no value is reinterpreted. The block sits between the parallel activation stage and the time-multiplexed MAC stage of the MPC inference pipeline, with valid/ready handshakes on both sides.

## Interface

Parameters:
- N_ELEM, 8: elements per vector; must be ≥ 2.
- W_IN, 20: ReLU output width (unsigned magnitude, Q6.14).
- W_OUT, 21: output width (signed ap_fixed<21,7>); must equal W_IN+1.

Ports:
- ap_clk  in  1  sole clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_vec  in  N_ELEM*W_IN  packed vector; element i is bits [i*W_IN +: W_IN].
- in_vld  in  1  in_vec is valid.
- in_rdy  out  1  block can load a vector this cycle.
- out_data  out  W_OUT  current element, {1'b0, elem}.
- out_vld  out  1  out_data is valid.
- out_rdy  in  1  downstream accepts out_data.
- out_idx  out  clog2(N_ELEM)  index of the current element.
- out_last  out  1  the current element is N_ELEM-1.
- nz_count  out  clog2(N_ELEM+1)  count of nonzero elements in the most recently loaded vector.
- busy  out  1  a vector is being replayed (equals out_vld).

## Operation

- **State machine**, two states:
  - IDLE: in_rdy=1, out_vld=0.
  - SEND: out_vld=1; element idx is presented.
- **Load.** The transfer condition is in_vld && in_rdy.
  - The whole in_vec is captured into an internal N_ELEM×W_IN register.
  - idx is set to 0 and the state goes to SEND.
  - nz_count is set to the number of elements that are not 0.
- **Beat.** An output beat completes when out_vld && out_rdy. If idx < N_ELEM-1, idx increments.
- **Last beat** (out_last && out_rdy):
  - If in_vld is 1 in the same cycle, the new vector loads and the state stays SEND with idx=0. This gives back-to-back vectors with no bubble.
  - Otherwise the state returns to IDLE and idx goes to 0.
- **in_rdy decode.** in_rdy = (state==IDLE) || (out_last && out_rdy). It is a combinational decode of registered state and out_rdy.
- **Stall.** While out_vld && !out_rdy, out_data, out_idx and out_last hold stable and the vector register is not written.
- **Output format.** out_data MSB is always 0. The block never truncates or saturates.
- **nz_count hold.** nz_count holds its value until the next load. It is not cleared on the return to IDLE.

## Timing

- Reset values while ap_rst_n=0:
  - state=IDLE, idx=0, out_vld=0, busy=0, out_last=0, nz_count=0.
  - out_data=0 and the vector register is 0.
  - in_rdy=1.
- Reset asserted mid-vector aborts the replay immediately. After release the block is in IDLE and the remaining elements are lost.
- Latency: a vector loaded at edge k shows element 0 with out_vld=1 in cycle k+1.
- Throughput: one element per cycle with out_rdy held high, so N_ELEM cycles per vector when loads are back-to-back.
- Output signals are registered or derived from registered idx, except that in_rdy depends combinationally on out_rdy.
- in_vld asserted in SEND before the last beat is not accepted. The source must hold in_vec and in_vld until in_rdy.

## Test plan

- **Basic replay.** N_ELEM=8; load elements 0x00000, 0x00001, 0xFFFFF, 0x4000, 0, 0, 0x12345, 0x80000 with out_rdy=1.
  - Required: 8 beats in cycles k+1..k+8 with out_data 0x000000, 0x000001, 0x0FFFFF, 0x004000, 0, 0, 0x012345, 0x080000.
  - out_last is set only on idx 7; nz_count=5.
- **Back-to-back.** Hold in_vld high with vector A (all 0x00001) then vector B (all 0x00002).
  - Required: 16 consecutive beats with no out_vld gap.
  - B is accepted on A's idx-7 cycle.
- **Backpressure.** Drop out_rdy for 3 cycles at idx 3.
  - Required: out_data and out_idx=3 hold for all 3 cycles.
  - Resumes with idx 4; total beats = 8; in_rdy stays 0 during the stall.
- **Early in_vld.** Assert in_vld at idx 2 with a new vector.
  - Required: in_rdy=0 until the idx-7 beat.
  - The old vector completes unchanged, then the new vector loads.
- **Reset mid-vector.** Assert ap_rst_n=0 asynchronously at idx 4.
  - Required: out_vld=0, nz_count=0 and in_rdy=1 immediately.
  - After release, a fresh load replays from idx 0.
- **All-zero vector.**
  - Required: 8 beats of 0x000000 and nz_count=0.
